// File: rtl/lcd_text_ctrl.sv
// Character LCD controller: waits for power-up, sends the 8-bit init sequence,
// then redraws the whole screen from an internal character buffer on request.
module lcd_text_ctrl #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned E_PULSE_CYC = 12,
    parameter int unsigned CMD_WAIT_US = 50,
    parameter int unsigned CLR_WAIT_US = 2000,
    parameter int unsigned PWR_WAIT_US = 20000,
    localparam int unsigned AW         = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          power_en,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [7:0]    buf_data,
    input  logic          refresh_req,
    output logic          ready,
    output logic          busy,
    output logic          RS,
    output logic          RW,
    output logic          E,
    output logic [7:0]    Data_Bus
);

    localparam int unsigned DEPTH = ROWS * COLS;

    localparam longint unsigned PWR_RAW = (64'(PWR_WAIT_US) * 64'(CLK_HZ)) / 64'd1_000_000;
    localparam longint unsigned CMD_RAW = (64'(CMD_WAIT_US) * 64'(CLK_HZ)) / 64'd1_000_000;
    localparam longint unsigned CLR_RAW = (64'(CLR_WAIT_US) * 64'(CLK_HZ)) / 64'd1_000_000;

    // A computed wait of zero cycles still costs one cycle.
    localparam longint unsigned PWR_CYC = (PWR_RAW == 64'd0) ? 64'd1 : PWR_RAW;
    localparam longint unsigned CMD_CYC = (CMD_RAW == 64'd0) ? 64'd1 : CMD_RAW;
    localparam longint unsigned CLR_CYC = (CLR_RAW == 64'd0) ? 64'd1 : CLR_RAW;
    localparam longint unsigned E_CYC   = (E_PULSE_CYC == 0) ? 64'd1 : 64'(E_PULSE_CYC);

    localparam longint unsigned MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam longint unsigned MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam longint unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;

    localparam int unsigned CW  = $clog2(MAX_CYC + 64'd1);
    localparam int unsigned CCW = $clog2(COLS);
    localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0]  PWR_LAST = CW'(PWR_CYC - 64'd1);
    localparam logic [CW-1:0]  CMD_LAST = CW'(CMD_CYC - 64'd1);
    localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_CYC - 64'd1);
    localparam logic [CW-1:0]  E_LAST   = CW'(E_CYC - 64'd1);
    localparam logic [CCW-1:0] COL_LAST = CCW'(COLS - 1);
    localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR_WAIT,
        S_INIT,
        S_IDLE,
        S_ROW_ADDR,
        S_CHAR,
        S_STROBE,
        S_WAIT
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return (ROWS == 1) ? 8'h30 : 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(COLS);
            default: return 8'(32'h40 + COLS);
        endcase
    endfunction

    function automatic logic [AW-1:0] buf_idx(input logic [RCW-1:0] row, input logic [CCW-1:0] col);
        return AW'(32'(row) * COLS + 32'(col));
    endfunction

    state_t          r_state, w_state_n;
    state_t          r_src,   w_src_n;
    logic [CW-1:0]   r_cnt,   w_cnt_n;
    logic [1:0]      r_idx,   w_idx_n;
    logic [RCW-1:0]  r_row,   w_row_n;
    logic [CCW-1:0]  r_col,   w_col_n;
    logic            r_long,  w_long_n;
    logic            r_pend,  w_pend_n;
    logic            r_rs,    w_rs_n;
    logic [7:0]      r_data,  w_data_n;
    logic            r_e;
    logic            r_ready;
    logic            r_busy;
    logic [7:0]      r_buf [DEPTH];

    // Character buffer: writable in every state, out-of-range writes dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (buf_we && (32'(buf_addr) < DEPTH)) begin
            r_buf[buf_addr] <= buf_data;
        end
    end

    // Next state; the bus byte for a transfer is latched as its setup state is entered.
    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_row_n   = r_row;
        w_col_n   = r_col;
        w_long_n  = r_long;
        w_rs_n    = r_rs;
        w_data_n  = r_data;
        w_pend_n  = r_pend || (refresh_req && (r_state != S_OFF) && (r_state != S_IDLE));

        case (r_state)
            S_OFF: begin
                if (power_en) begin
                    w_state_n = S_PWR_WAIT;
                    w_cnt_n   = '0;
                end
            end
            S_PWR_WAIT: begin
                if (r_cnt == PWR_LAST) begin
                    w_state_n = S_INIT;
                    w_idx_n   = '0;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_INIT, S_ROW_ADDR, S_CHAR: begin
                w_state_n = S_STROBE;
                w_src_n   = r_state;
                w_cnt_n   = '0;
            end
            S_STROBE: begin
                if (r_cnt == E_LAST) begin
                    w_state_n = S_WAIT;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (r_cnt == (r_long ? CLR_LAST : CMD_LAST)) begin
                    w_cnt_n = '0;
                    case (r_src)
                        S_INIT: begin
                            if (r_idx == 2'd3) begin
                                w_state_n = S_IDLE;
                            end else begin
                                w_idx_n   = r_idx + 2'd1;
                                w_state_n = S_INIT;
                            end
                        end
                        S_ROW_ADDR: begin
                            w_col_n   = '0;
                            w_state_n = S_CHAR;
                        end
                        default: begin
                            if (r_col != COL_LAST) begin
                                w_col_n   = r_col + CCW'(1);
                                w_state_n = S_CHAR;
                            end else if (r_row != ROW_LAST) begin
                                w_row_n   = r_row + RCW'(1);
                                w_state_n = S_ROW_ADDR;
                            end else begin
                                w_state_n = S_IDLE;
                            end
                        end
                    endcase
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_IDLE: begin
                if (refresh_req || r_pend) begin
                    w_state_n = S_ROW_ADDR;
                    w_row_n   = '0;
                    w_pend_n  = 1'b0;
                end
            end
        endcase

        if (!power_en) begin
            w_state_n = S_OFF;
            w_pend_n  = 1'b0;
            w_cnt_n   = '0;
        end

        case (w_state_n)
            S_OFF: begin
                w_rs_n   = 1'b0;
                w_data_n = 8'h00;
                w_long_n = 1'b0;
            end
            S_INIT: begin
                w_rs_n   = 1'b0;
                w_data_n = init_cmd(w_idx_n);
                w_long_n = (w_idx_n == 2'd2);
            end
            S_ROW_ADDR: begin
                w_rs_n   = 1'b0;
                w_data_n = 8'h80 | row_base(2'(w_row_n));
                w_long_n = 1'b0;
            end
            S_CHAR: begin
                w_rs_n   = 1'b1;
                w_data_n = r_buf[buf_idx(w_row_n, w_col_n)];
                w_long_n = 1'b0;
            end
            default: ;
        endcase
    end

    // State register and registered LCD / status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_OFF;
            r_src   <= S_INIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_long  <= 1'b0;
            r_pend  <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_src   <= w_src_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_long  <= w_long_n;
            r_pend  <= w_pend_n;
            r_rs    <= w_rs_n;
            r_data  <= w_data_n;
            r_e     <= (w_state_n == S_STROBE);
            r_ready <= (w_state_n == S_IDLE);
            r_busy  <= (w_state_n != S_OFF) && (w_state_n != S_IDLE);
        end
    end

    assign RS       = r_rs;
    assign RW       = 1'b0;
    assign E        = r_e;
    assign Data_Bus = r_data;
    assign ready    = r_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed/randomized bench for lcd_text_ctrl: a 8x2 instance for the main
// scenarios and a 12x1 instance that can address out-of-range buffer slots.
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned E_PULSE_CYC = 2;
    localparam int unsigned CMD_WAIT_US = 3;
    localparam int unsigned CLR_WAIT_US = 10;
    localparam int unsigned PWR_WAIT_US = 5;
    localparam int unsigned COLS0 = 8,  ROWS0 = 2;
    localparam int unsigned COLS1 = 12, ROWS1 = 1;
    localparam int BOUND = 3000;

    logic       clk, reset_n;
    logic       pwr0, we0, ref0, rdy0, bsy0, rs0, rw0, e0;
    logic [3:0] addr0;
    logic [7:0] din0, db0;
    logic       pwr1, we1, ref1, rdy1, bsy1, rs1, rw1, e1;
    logic [3:0] addr1;
    logic [7:0] din1, db1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb0 [16];
    logic [7:0] mb1 [12];
    logic [8:0] cap0 [$];
    logic [8:0] cap1 [$];
    logic [8:0] expq [$];
    logic       pe0 = 1'b0, pe1 = 1'b0;

    lcd_text_ctrl #(
        .CLK_HZ(CLK_HZ), .COLS(COLS0), .ROWS(ROWS0), .E_PULSE_CYC(E_PULSE_CYC),
        .CMD_WAIT_US(CMD_WAIT_US), .CLR_WAIT_US(CLR_WAIT_US), .PWR_WAIT_US(PWR_WAIT_US)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .power_en(pwr0), .buf_we(we0), .buf_addr(addr0),
        .buf_data(din0), .refresh_req(ref0), .ready(rdy0), .busy(bsy0), .RS(rs0),
        .RW(rw0), .E(e0), .Data_Bus(db0)
    );

    lcd_text_ctrl #(
        .CLK_HZ(CLK_HZ), .COLS(COLS1), .ROWS(ROWS1), .E_PULSE_CYC(E_PULSE_CYC),
        .CMD_WAIT_US(CMD_WAIT_US), .CLR_WAIT_US(CLR_WAIT_US), .PWR_WAIT_US(PWR_WAIT_US)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .power_en(pwr1), .buf_we(we1), .buf_addr(addr1),
        .buf_data(din1), .refresh_req(ref1), .ready(rdy1), .busy(bsy1), .RS(rs1),
        .RW(rw1), .E(e1), .Data_Bus(db1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record {RS, Data_Bus} at every rising edge of E.
    always @(negedge clk) begin
        if (e0 && !pe0) cap0.push_back({rs0, db0});
        if (e1 && !pe1) cap1.push_back({rs1, db1});
        pe0 <= e0;
        pe1 <= e1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int us_to_cyc(input int unsigned us);
        longint unsigned c;
        c = (longint'(us) * longint'(CLK_HZ)) / 64'd1_000_000;
        return (c == 0) ? 1 : int'(c);
    endfunction

    task automatic buf_write(input int which, input int a, input logic [7:0] d);
        if (which == 0) begin
            we0 = 1'b1; addr0 = 4'(a); din0 = d;
            if (a < 16) mb0[a] = d;
        end else begin
            we1 = 1'b1; addr1 = 4'(a); din1 = d;
            if (a < 12) mb1[a] = d;
        end
        @(negedge clk);
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic pulse_ref(input int which);
        if (which == 0) ref0 = 1'b1; else ref1 = 1'b1;
        @(negedge clk);
        ref0 = 1'b0;
        ref1 = 1'b0;
    endtask

    task automatic wait_ready(input int which, input string tag);
        int n = 0;
        while (((which == 0) ? rdy0 : rdy1) !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'((which == 0) ? rdy0 : rdy1), 32'd1);
    endtask

    task automatic wait_caps(input int which, input int cnt, input string tag);
        int n = 0;
        while (((which == 0) ? cap0.size() : cap1.size()) < cnt && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'((which == 0) ? cap0.size() : cap1.size()), 32'(cnt));
    endtask

    task automatic exp_init(input int rows);
        expq.push_back({1'b0, (rows == 1) ? 8'h30 : 8'h38});
        expq.push_back({1'b0, 8'h0C});
        expq.push_back({1'b0, 8'h01});
        expq.push_back({1'b0, 8'h06});
    endtask

    task automatic exp_redraw(input int which);
        int cols = (which == 0) ? int'(COLS0) : int'(COLS1);
        int rows = (which == 0) ? int'(ROWS0) : int'(ROWS1);
        for (int r = 0; r < rows; r++) begin
            expq.push_back({1'b0, 8'(8'h80 + (r % 2) * 64 + (r / 2) * cols)});
            for (int c = 0; c < cols; c++) begin
                expq.push_back({1'b1, (which == 0) ? mb0[r * cols + c] : mb1[r * cols + c]});
            end
        end
    endtask

    task automatic cmp_caps(input int which, input string tag);
        int got_n = (which == 0) ? cap0.size() : cap1.size();
        int n = (got_n < expq.size()) ? got_n : expq.size();
        check({tag, "_len"}, 32'(got_n), 32'(expq.size()));
        for (int i = 0; i < n; i++) begin
            check(tag, 32'((which == 0) ? cap0[i] : cap1[i]), 32'(expq[i]));
        end
    endtask

    initial begin
        logic [11:0] tr [$];
        logic [7:0]  cmds [4];
        int          n;

        reset_n = 1'b0;
        pwr0 = 1'b0; we0 = 1'b0; ref0 = 1'b0; addr0 = '0; din0 = '0;
        pwr1 = 1'b0; we1 = 1'b0; ref1 = 1'b0; addr1 = '0; din1 = '0;
        for (int i = 0; i < 16; i++) mb0[i] = 8'h20;
        for (int i = 0; i < 12; i++) mb1[i] = 8'h20;

        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, rdy0, bsy0, e0, rs0, db0}, 32'd0);
        check("reset_rw", 32'(rw0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("off_idle", {20'd0, rdy0, bsy0, e0, rs0, db0}, 32'd0);

        // Scenario 1: cycle-exact init trace {ready,busy,E,RS,Data}.
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
        for (int i = 0; i < us_to_cyc(PWR_WAIT_US); i++) tr.push_back({1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        for (int k = 0; k < 4; k++) begin
            tr.push_back({1'b0, 1'b1, 1'b0, 1'b0, cmds[k]});
            for (int i = 0; i < int'(E_PULSE_CYC); i++) tr.push_back({1'b0, 1'b1, 1'b1, 1'b0, cmds[k]});
            n = (cmds[k] == 8'h01) ? us_to_cyc(CLR_WAIT_US) : us_to_cyc(CMD_WAIT_US);
            for (int i = 0; i < n; i++) tr.push_back({1'b0, 1'b1, 1'b0, 1'b0, cmds[k]});
        end
        pwr0 = 1'b1;
        foreach (tr[i]) begin
            @(negedge clk);
            check("init_trace", {20'd0, rdy0, bsy0, e0, rs0, db0}, {20'd0, tr[i]});
        end
        @(negedge clk);
        check("init_ready", {30'd0, rdy0, bsy0}, 32'b10);
        cap0.delete();

        // Scenario 2: fixed text, single redraw.
        for (int i = 0; i < 8; i++) begin
            buf_write(0, i, 8'(8'h41 + i));
            buf_write(0, 8 + i, 8'(8'h31 + i));
        end
        pulse_ref(0);
        wait_ready(0, "scn2_ready");
        expq.delete();
        exp_redraw(0);
        cmp_caps(0, "scn2_redraw");
        cap0.delete();

        // Scenario 3: extra requests during a redraw collapse into one more.
        for (int i = 0; i < 16; i++) buf_write(0, i, 8'($urandom_range(32, 126)));
        pulse_ref(0);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 25)) @(negedge clk);
            pulse_ref(0);
        end
        wait_caps(0, 36, "scn3_caps");
        wait_ready(0, "scn3_ready");
        repeat (150) @(negedge clk);
        check("scn3_count", 32'(cap0.size()), 32'd36);
        check("scn3_idle", 32'(rdy0), 32'd1);
        expq.delete();
        exp_redraw(0);
        exp_redraw(0);
        cmp_caps(0, "scn3_redraw");
        cap0.delete();

        // Scenario 4: power drop mid-character with a pending request queued.
        pulse_ref(0);
        wait_caps(0, 3, "scn4_start");
        pulse_ref(0);
        n = 0;
        while (!(e0 === 1'b1 && rs0 === 1'b1) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("scn4_in_char", {30'd0, e0, rs0}, 32'b11);
        pwr0 = 1'b0;
        @(negedge clk);
        check("scn4_off", {20'd0, rdy0, bsy0, e0, rs0, db0}, 32'd0);
        repeat (3) @(negedge clk);
        check("scn4_stay_off", {20'd0, rdy0, bsy0, e0, rs0, db0}, 32'd0);
        cap0.delete();
        pwr0 = 1'b1;
        wait_caps(0, 4, "scn4_reinit_caps");
        wait_ready(0, "scn4_reinit_ready");
        expq.delete();
        exp_init(2);
        cmp_caps(0, "scn4_reinit");
        repeat (200) @(negedge clk);
        check("scn4_no_pending", 32'(cap0.size()), 32'd4);
        cap0.delete();
        pulse_ref(0);
        wait_ready(0, "scn4_redraw_ready");
        expq.delete();
        exp_redraw(0);
        cmp_caps(0, "scn4_buf_kept");
        cap0.delete();

        // Scenario 5: asynchronous reset while E is high.
        pulse_ref(0);
        n = 0;
        while (e0 !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("scn5_in_strobe", 32'(e0), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("scn5_async", {20'd0, rdy0, bsy0, e0, rs0, db0}, 32'd0);
        check("scn5_rw", 32'(rw0), 32'd0);
        for (int i = 0; i < 16; i++) mb0[i] = 8'h20;
        @(negedge clk);
        reset_n = 1'b1;
        cap0.delete();
        wait_caps(0, 4, "scn5_init_caps");
        wait_ready(0, "scn5_ready");
        expq.delete();
        exp_init(2);
        cmp_caps(0, "scn5_init");
        cap0.delete();
        pulse_ref(0);
        wait_ready(0, "scn5_redraw_ready");
        expq.delete();
        exp_redraw(0);
        cmp_caps(0, "scn5_blank");

        // Scenario 6: single-row instance, writes beyond the buffer are dropped.
        pwr1 = 1'b1;
        wait_caps(1, 4, "scn6_init_caps");
        wait_ready(1, "scn6_ready");
        expq.delete();
        exp_init(1);
        cmp_caps(1, "scn6_init");
        cap1.delete();
        for (int i = 0; i < 12; i++) buf_write(1, i, 8'($urandom_range(32, 126)));
        for (int i = 12; i < 16; i++) buf_write(1, i, 8'h5A);
        pulse_ref(1);
        wait_ready(1, "scn6_redraw_ready");
        expq.delete();
        exp_redraw(1);
        cmp_caps(1, "scn6_redraw");
        check("scn6_rw", 32'(rw1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
